// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM states, line-control bit positions
// and the parity rule used by both the core and its scoreboard.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam int LCR_WLS    = 0;  // two bits: word length 5..8
    localparam int LCR_STB    = 2;
    localparam int LCR_PEN    = 3;
    localparam int LCR_EPS    = 4;
    localparam int LCR_STICK  = 5;
    localparam int LCR_BRK    = 6;
    localparam int OVERSAMPLE = 16;

    function automatic logic calc_parity(input logic [7:0] lcr, input logic [7:0] data);
        logic [7:0] mask;
        logic       x;
        case (lcr[LCR_WLS +: 2])
            2'd0:    mask = 8'h1F;
            2'd1:    mask = 8'h3F;
            2'd2:    mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        x = ^(data & mask);
        if (lcr[LCR_STICK]) begin
            calc_parity = ~lcr[LCR_EPS];
        end else if (lcr[LCR_EPS]) begin
            calc_parity = x;
        end else begin
            calc_parity = ~x;
        end
    endfunction

endpackage

// File: rtl/uart_tx_core_baud_gen.sv
// 16x oversample tick generator: one tick every `divisor` clocks, restartable
// so a new frame always begins on a clean bit boundary.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick,
    output logic             tick_early
);

    logic [DIV_W-1:0] presc_r;
    logic [DIV_W-1:0] presc_next_s;
    logic [DIV_W-1:0] div_m1_s;

    // Next prescaler value; wraps at divisor-1.
    always_comb begin
        div_m1_s = divisor - {{(DIV_W-1){1'b0}}, 1'b1};
        if (clear) begin
            presc_next_s = '0;
        end else if (presc_r == div_m1_s) begin
            presc_next_s = '0;
        end else begin
            presc_next_s = presc_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_next_s;
        end
    end

    // tick_early says the coming cycle carries a tick, letting the core end a
    // frame one clock ahead so back-to-back frames have no gap.
    assign tick       = (presc_r == div_m1_s);
    assign tick_early = (presc_next_s == div_m1_s);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready byte intake, 16550-style word format,
// registered serial output with live break override.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] divisor,
    input  logic [7:0]       lcr,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             txd,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam logic [5:0] BIT_LAST   = 6'(OVERSAMPLE - 1);
    localparam logic [5:0] STOP1_LAST = 6'(OVERSAMPLE - 1);
    localparam logic [5:0] STOP15_LAST = 6'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
    localparam logic [5:0] STOP2_LAST = 6'(2 * OVERSAMPLE - 1);

    uart_tx_state_e   state_r, state_next_s;
    logic [DIV_W-1:0] div_r;
    logic [5:0]       lcr_r;
    logic [7:0]       data_r;
    logic [5:0]       tick_cnt_r, tick_cnt_next_s, tick_cnt_plus_s;
    logic [2:0]       bit_idx_r, bit_idx_next_s;
    logic [2:0]       last_bit_s;
    logic [5:0]       stop_last_s;
    logic             txd_r, ready_r, done_r;
    logic             accept_s, done_s, fsm_txd_s;
    logic             tick_s, tick_early_s;
    logic             unused_s;

    assign unused_s = lcr[7];
    assign accept_s = tx_valid & ready_r;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept_s),
        .divisor    (div_r),
        .tick       (tick_s),
        .tick_early (tick_early_s)
    );

    // Frame geometry from the latched line-control bits.
    always_comb begin
        last_bit_s      = 3'd4 + {1'b0, lcr_r[LCR_WLS +: 2]};
        tick_cnt_plus_s = tick_s ? (tick_cnt_r + 6'd1) : tick_cnt_r;
        if (!lcr_r[LCR_STB]) begin
            stop_last_s = STOP1_LAST;
        end else if (lcr_r[LCR_WLS +: 2] == 2'd0) begin
            stop_last_s = STOP15_LAST;
        end else begin
            stop_last_s = STOP2_LAST;
        end
    end

    // Next-state, tick/bit counters and end-of-frame strobe.
    always_comb begin
        state_next_s    = state_r;
        tick_cnt_next_s = tick_cnt_r;
        bit_idx_next_s  = bit_idx_r;
        done_s          = 1'b0;
        case (state_r)
            IDLE: begin
                tick_cnt_next_s = 6'd0;
                bit_idx_next_s  = 3'd0;
                if (accept_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START, PARITY: begin
                if (tick_s && (tick_cnt_r == BIT_LAST)) begin
                    tick_cnt_next_s = 6'd0;
                    state_next_s    = (state_r == START) ? DATA : STOP;
                end else begin
                    tick_cnt_next_s = tick_cnt_plus_s;
                end
            end
            DATA: begin
                if (tick_s && (tick_cnt_r == BIT_LAST)) begin
                    tick_cnt_next_s = 6'd0;
                    if (bit_idx_r == last_bit_s) begin
                        bit_idx_next_s = 3'd0;
                        state_next_s   = lcr_r[LCR_PEN] ? PARITY : STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    tick_cnt_next_s = tick_cnt_plus_s;
                end
            end
            STOP: begin
                // Leave one clock before the final tick lands so the last stop
                // cycle doubles as the IDLE/accept cycle.
                if (tick_early_s && (tick_cnt_plus_s == stop_last_s)) begin
                    tick_cnt_next_s = 6'd0;
                    state_next_s    = IDLE;
                    done_s          = 1'b1;
                end else begin
                    tick_cnt_next_s = tick_cnt_plus_s;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Line level implied by the state being entered.
    always_comb begin
        case (state_next_s)
            START:   fsm_txd_s = 1'b0;
            DATA:    fsm_txd_s = data_r[bit_idx_next_s];
            PARITY:  fsm_txd_s = calc_parity({2'b00, lcr_r}, data_r);
            default: fsm_txd_s = 1'b1;
        endcase
    end

    // State, counters, frame latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            tick_cnt_r <= 6'd0;
            bit_idx_r  <= 3'd0;
            div_r      <= '0;
            lcr_r      <= 6'd0;
            data_r     <= 8'd0;
            txd_r      <= 1'b1;
            ready_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            tick_cnt_r <= tick_cnt_next_s;
            bit_idx_r  <= bit_idx_next_s;
            if (accept_s) begin
                div_r  <= divisor;
                lcr_r  <= lcr[5:0];
                data_r <= tx_data;
            end else begin
                div_r  <= div_r;
                lcr_r  <= lcr_r;
                data_r <= data_r;
            end
            txd_r   <= lcr[LCR_BRK] ? 1'b0 : fsm_txd_s;
            ready_r <= (state_next_s == IDLE) && (divisor != '0);
            done_r  <= done_s;
        end
    end

    assign txd      = txd_r;
    assign tx_ready = ready_r;
    assign tx_done  = done_r;
    assign tx_busy  = (state_r != IDLE);

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Synthesizable UART transmitter for the ucontroller serial port.
- Accepts bytes over a valid/ready handshake and serializes them on `txd`.
- Frame is start bit, 5-8 data bits LSB first, optional parity bit, then 1/1.5/2 stop bits.
- Word format is selected by a 16550-style line-control byte; bit rate is set by a 16-bit divisor driving a 16x oversample tick.

Parameters:
- DIV_W, 16, divisor width.
- OVERSAMPLE, 16, ticks per bit period (fixed at 16; 1.5-stop timing depends on it).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- divisor  in  16  baud divisor; one 16x tick every `divisor` clk cycles
- lcr  in  8  [1:0] word length 5/6/7/8; [2] stop select; [3] parity enable; [4] even parity; [5] stick parity; [6] break
- tx_data  in  8  byte to send; bits above the word length are ignored
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  core can accept a byte
- txd  out  1  serial output, idles high
- tx_busy  out  1  frame in progress
- tx_done  out  1  one-cycle pulse at end of the last stop bit

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: txd=1, tx_ready=0, tx_busy=0, tx_done=0, state=IDLE, counters=0. tx_ready rises on the first edge after rst_n=1, provided divisor!=0.
- Reset mid-frame: txd returns to 1 at that edge; the partial frame is abandoned and not resumed.
- Handshake:
  - A transfer occurs on a rising edge with tx_valid & tx_ready.
  - tx_data, lcr[5:0] and divisor are latched at acceptance.
  - Changes to these inputs mid-frame have no effect on the current frame.
  - tx_ready is low from the edge after acceptance until the end of the frame.
- Baud generation:
  - Prescaler counts 0..divisor-1 and is cleared on acceptance.
  - One tick is issued per divisor cycles; one bit = 16 ticks = 16*divisor clk cycles.
  - divisor=0: tx_ready held 0 in IDLE and no frame starts; txd=1.
- FSM: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: txd=1, tx_ready=1 when divisor!=0.
  - START: txd=0 from the edge after acceptance, for 16 ticks.
  - DATA: N=5+lcr[1:0] bits, LSB first, 16 ticks each.
  - PARITY, entered only if lcr[3]:
    - stick (lcr[5]=1): bit = ~lcr[4]
    - otherwise: bit = XOR of the N data bits, inverted when lcr[4]=0 (odd parity)
  - STOP: txd=1.
    - lcr[2]=0: 16 ticks.
    - lcr[2]=1 and N=5: 24 ticks.
    - lcr[2]=1 and N>5: 32 ticks.
  - End of STOP: tx_done pulses for 1 cycle and state returns to IDLE with tx_ready=1 in the same cycle.
  - If tx_valid is high in that cycle the next byte is accepted, and its start bit begins the following edge, so there is zero idle gap.
- Frame length: 16*divisor*(1+N+P) + stop ticks*divisor cycles, counted from the edge after acceptance to the tx_done edge inclusive.
- tx_busy = (state != IDLE).
- Break:
  - lcr[6] is live and not latched.
  - While lcr[6]=1, txd=0 regardless of state; the FSM keeps its timing unchanged.
  - After break is released, txd follows the FSM again on the next edge.
- txd is registered, with no combinational path from the inputs.

Decomposition:
- Shared package uart_pkg:
  - `uart_tx_state_e` enum: IDLE, START, DATA, PARITY, STOP.
  - LCR bit index constants: LCR_WLS, LCR_STB, LCR_PEN, LCR_EPS, LCR_STICK, LCR_BRK.
  - Constant OVERSAMPLE=16.
  - Function `calc_parity(lcr, data)` returning the parity bit, so the RTL and the bench scoreboard share one definition.
- Sub-module uart_baud_gen:
  - Inputs: clk, rst_n, clear, divisor.
  - Output: a 1-cycle tick pulse.

Test Plan:
- 8N1 (lcr=0x03), divisor=1, send 0x55:
  - txd = 0,1,0,1,0,1,0,1,0,1, each held 16 cycles.
  - tx_done exactly 160 cycles after acceptance; tx_ready back to 1 in the same cycle.
- 8E1 (lcr=0x1B), divisor=2, send 0x07:
  - parity bit=1.
  - frame = 11 bits * 32 = 352 cycles.
- 8O1 (lcr=0x0B), send 0x07: parity bit=0. Stick parity (lcr=0x2B): parity bit=1.
- 5N1.5 (lcr=0x04), divisor=1, send 0xFF:
  - data 1,1,1,1,1.
  - stop bit high for 24 cycles; total 120 cycles.
- Back-to-back, tx_valid held with 0xA5 then 0x3C, 7N2 (lcr=0x06):
  - second start bit begins on the edge right after the first tx_done.
  - no idle high gap beyond the 32-cycle stop.
- Reset and control corner cases:
  - rst_n low mid-DATA of 0xF0: txd=1 next edge, tx_busy=0; tx_ready=1 one edge after reset release.
  - lcr[6] pulsed mid-frame: txd=0 throughout the pulse; frame length unchanged.
  - divisor=0: tx_ready stays 0 and txd stays 1.
